// File: rtl/booth_mul_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller:
// operand/iteration count, counter width, state encoding, Booth pair
// constants and the strobe bundle driven towards the datapath.
package booth_mul_ctrl_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned CNT_W = 5;

  // {Q[0], Q[-1]} pairs that need an AddSub pass before the shift
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_Q = 3'd1,
    S_EVAL   = 3'd2,
    S_ADD    = 3'd3,
    S_SUB    = 3'd4,
    S_SHIFT  = 3'd5,
    S_CHECK  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  // Datapath control strobes, one bit per register/unit action
  typedef struct packed {
    logic ld_m;
    logic ld_q;
    logic ld_a;
    logic clr_a;
    logic clr_ff;
    logic sft_a;
    logic sft_q;
    logic oper;
    logic ld_cnt;
    logic decr;
  } strobe_t;

  // Next state out of EVAL for a given {Q[0], Q[-1]} pair
  function automatic state_e booth_step(input logic [1:0] pair);
    state_e s;
    case (pair)
      BOOTH_SUB: s = S_SUB;
      BOOTH_ADD: s = S_ADD;
      default:   s = S_SHIFT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/booth_mul_ctrl_if.sv
// Controller <-> datapath/scheduler signal bundle.
//   in_valid/in_ready   : operand word handshake on the shared data bus
//   out_valid/out_ready : product handshake towards the DCT scheduler
//   abort               : synchronous cancel
//   q0/qm1/eqz          : datapath status (Q[0], Q[-1], counter == 0)
//   ldM..decr           : datapath strobes; busy = controller not idle
// master = controller side, slave = datapath/scheduler side.
interface booth_mul_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic abort;
  logic q0;
  logic qm1;
  logic eqz;
  logic ldM;
  logic ldQ;
  logic ldA;
  logic clrA;
  logic clrff;
  logic sftA;
  logic sftQ;
  logic oper;
  logic ldcnt;
  logic decr;
  logic busy;

  modport master (
    input  in_valid, out_ready, abort, q0, qm1, eqz,
    output in_ready, out_valid, ldM, ldQ, ldA, clrA, clrff,
           sftA, sftQ, oper, ldcnt, decr, busy
  );

  modport slave (
    output in_valid, out_ready, abort, q0, qm1, eqz,
    input  in_ready, out_valid, ldM, ldQ, ldA, clrA, clrff,
           sftA, sftQ, oper, ldcnt, decr, busy
  );

endinterface

// File: rtl/booth_mul_ctrl_dec.sv
// Combinational state/input to strobe decoder for the Booth controller.
//   i_state      : current FSM state
//   i_rst        : reset level, suppresses the IDLE load strobes
//   i_in_valid   : operand word present
//   i_abort      : cancel request, silences every non-IDLE state
//   o_strb_c     : datapath strobes
//   o_in_ready_c, o_out_valid_c, o_busy_c : handshake/status outputs
module booth_mul_ctrl_dec
  import booth_mul_ctrl_pkg::*;
(
  input  state_e  i_state,
  input  logic    i_rst,
  input  logic    i_in_valid,
  input  logic    i_abort,
  output strobe_t o_strb_c,
  output logic    o_in_ready_c,
  output logic    o_out_valid_c,
  output logic    o_busy_c
);

  // Strobe decode: Moore from state, except the operand-load strobes in IDLE/WAIT_Q
  always_comb begin
    o_strb_c      = '0;
    o_in_ready_c  = 1'b0;
    o_out_valid_c = 1'b0;
    o_busy_c      = (i_state != S_IDLE);

    if (i_state == S_IDLE) begin
      // abort has no meaning here; reset keeps the M load from firing
      o_in_ready_c = 1'b1;
      if (i_in_valid && !i_rst) begin
        o_strb_c.ld_m   = 1'b1;
        o_strb_c.clr_a  = 1'b1;
        o_strb_c.clr_ff = 1'b1;
        o_strb_c.ld_cnt = 1'b1;
      end
    end else if (!i_abort) begin
      case (i_state)
        S_WAIT_Q: begin
          o_in_ready_c = 1'b1;
          if (i_in_valid) begin
            o_strb_c.ld_q = 1'b1;
          end
        end
        S_ADD: begin
          o_strb_c.ld_a = 1'b1;
        end
        S_SUB: begin
          o_strb_c.ld_a = 1'b1;
          o_strb_c.oper = 1'b1;
        end
        S_SHIFT: begin
          o_strb_c.sft_a = 1'b1;
          o_strb_c.sft_q = 1'b1;
          o_strb_c.decr  = 1'b1;
        end
        S_DONE: begin
          o_out_valid_c = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth shift-add multiplier controller. Takes M then Q over the
// shared bus, runs N evaluate/add-sub/shift/check iterations against the
// external datapath (which updates on negedge clk) and presents the
// product with a valid/ready handshake.
//   clk  : controller clock, state updates on posedge
//   clr  : asynchronous active-high reset
//   bus  : handshake, status and strobe bundle (master side)
module booth_mul_ctrl
  import booth_mul_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr,
  booth_mul_ctrl_if.master       bus
);

  state_e  r_state;
  state_e  w_next;
  strobe_t w_strb;
  logic    w_in_ready;
  logic    w_out_valid;
  logic    w_busy;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort outranks every transition outside IDLE
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.in_valid)  w_next = S_WAIT_Q;
        S_WAIT_Q: if (bus.in_valid)  w_next = S_EVAL;
        S_EVAL:   w_next = booth_step({bus.q0, bus.qm1});
        S_ADD:    w_next = S_SHIFT;
        S_SUB:    w_next = S_SHIFT;
        S_SHIFT:  w_next = S_CHECK;
        // eqz reflects the decrement made on the negedge inside SHIFT
        S_CHECK:  w_next = bus.eqz ? S_DONE : S_EVAL;
        S_DONE:   if (bus.out_ready) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  booth_mul_ctrl_dec u_dec (
    .i_state       (r_state),
    .i_rst         (clr),
    .i_in_valid    (bus.in_valid),
    .i_abort       (bus.abort),
    .o_strb_c      (w_strb),
    .o_in_ready_c  (w_in_ready),
    .o_out_valid_c (w_out_valid),
    .o_busy_c      (w_busy)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.ldM       = w_strb.ld_m;
  assign bus.ldQ       = w_strb.ld_q;
  assign bus.ldA       = w_strb.ld_a;
  assign bus.clrA      = w_strb.clr_a;
  assign bus.clrff     = w_strb.clr_ff;
  assign bus.sftA      = w_strb.sft_a;
  assign bus.sftQ      = w_strb.sft_q;
  assign bus.oper      = w_strb.oper;
  assign bus.ldcnt     = w_strb.ld_cnt;
  assign bus.decr      = w_strb.decr;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Bench for booth_mul_ctrl: a negedge datapath model closes the loop,
// results are judged against signed multiplication and Booth recoding
// counts of the multiplier.
module tb_booth_mul_ctrl;
  import booth_mul_ctrl_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b1;

  booth_mul_ctrl_if u_if ();

  booth_mul_ctrl u_dut (
    .clk (clk),
    .clr (clr),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int q_acc  = 0;
  bit oper_q[$];

  // Datapath environment: registers update on negedge from the strobes
  logic [15:0]      bus_data = '0;
  logic [15:0]      dp_a = '0, dp_q = '0, dp_m = '0;
  logic             dp_qm1 = 1'b0;
  logic [CNT_W-1:0] dp_cnt = CNT_W'(1);
  logic [9:0]       w_strb;

  assign u_if.q0  = dp_q[0];
  assign u_if.qm1 = dp_qm1;
  assign u_if.eqz = (dp_cnt == '0);
  assign w_strb = {u_if.ldM, u_if.ldQ, u_if.ldA, u_if.clrA, u_if.clrff,
                   u_if.sftA, u_if.sftQ, u_if.oper, u_if.ldcnt, u_if.decr};

  always @(negedge clk) begin
    if (u_if.ldM)   dp_m   <= bus_data;
    if (u_if.clrA)  dp_a   <= '0;
    if (u_if.clrff) dp_qm1 <= 1'b0;
    if (u_if.ldcnt) dp_cnt <= CNT_W'(N);
    if (u_if.ldQ)   dp_q   <= bus_data;
    if (u_if.ldA)   dp_a   <= u_if.oper ? dp_a - dp_m : dp_a + dp_m;
    if (u_if.sftA)  dp_a   <= {dp_a[15], dp_a[15:1]};
    if (u_if.sftQ) begin
      dp_q   <= {dp_a[0], dp_q[15:1]};
      dp_qm1 <= dp_q[0];
    end
    if (u_if.decr)  dp_cnt <= dp_cnt - CNT_W'(1);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle monitor: collects AddSub operations, checks strobe exclusivity
  always @(posedge clk) begin
    #3;
    if (!clr) begin
      checks++;
      if (u_if.ldA && u_if.sftA) begin
        errors++;
        $display("FAIL ldA_sftA_excl: ldA=%b sftA=%b at cycle %0d, required not both", u_if.ldA, u_if.sftA, cyc);
      end
      checks++;
      if (!u_if.ldA && u_if.oper !== 1'b0) begin
        errors++;
        $display("FAIL oper_idle: oper=%b without ldA at cycle %0d, required 0", u_if.oper, cyc);
      end
      if (u_if.ldA) oper_q.push_back(u_if.oper);
    end
  end

  function automatic logic [31:0] ref_prod(input logic [15:0] m, input logic [15:0] q);
    int sm, sq;
    sm = int'($signed(m));
    sq = int'($signed(q));
    return 32'(sm * sq);
  endfunction

  // Booth recoding: a change between adjacent multiplier bits needs an add (0->1 going down) or subtract
  function automatic void ref_ops(input logic [15:0] q, output bit ops[$]);
    logic prev;
    prev = 1'b0;
    ops.delete();
    for (int i = 0; i < 16; i++) begin
      if (q[i] && !prev) ops.push_back(1'b1);
      if (!q[i] && prev) ops.push_back(1'b0);
      prev = q[i];
    end
  endfunction

  task automatic send_word(input logic [15:0] w, input bit is_q);
    int n = 0;
    bus_data = w;
    u_if.in_valid = 1'b1;
    #1;
    while (!(is_q ? u_if.ldQ : u_if.ldM) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (!(is_q ? u_if.ldQ : u_if.ldM)) begin
      errors++;
      $display("FAIL %s_accept: load strobe=0 after %0d cycles, required 1", is_q ? "q" : "m", n);
    end
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    if (is_q) q_acc = cyc;
  endtask

  task automatic run_op(input logic [15:0] m, input logic [15:0] q, input int stall, input string nm);
    bit exp_ops[$];
    int n = 0;
    int lat;
    bit bad;
    logic [31:0] prod;
    ref_ops(q, exp_ops);
    oper_q.delete();
    send_word(m, 1'b0);
    send_word(q, 1'b1);
    while (n < 400) begin
      @(posedge clk); #2;
      if (u_if.out_valid) break;
      n++;
    end
    checks++;
    if (u_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: out_valid=%b, required 1", nm, u_if.out_valid);
    end
    lat = cyc - q_acc;
    checks++;
    if (lat != 3 * N + exp_ops.size()) begin
      errors++;
      $display("FAIL %s_latency: %0d cycles, required %0d", nm, lat, 3 * N + exp_ops.size());
    end
    prod = {dp_a, dp_q};
    checks++;
    if (prod !== ref_prod(m, q)) begin
      errors++;
      $display("FAIL %s_product: %h, required %h", nm, prod, ref_prod(m, q));
    end
    bad = (oper_q.size() != exp_ops.size());
    if (!bad) foreach (exp_ops[i]) if (oper_q[i] != exp_ops[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_oper_seq: %0d ops %p, required %0d ops %p", nm, oper_q.size(), oper_q, exp_ops.size(), exp_ops);
    end
    for (int i = 0; i < stall; i++) begin
      u_if.in_valid = 1'b1;
      bus_data = 16'h5A5A;
      #1;
      checks++;
      if (u_if.out_valid !== 1'b1 || u_if.in_ready !== 1'b0 || u_if.ldM !== 1'b0) begin
        errors++;
        $display("FAIL %s_stall: out_valid=%b in_ready=%b ldM=%b, required 1 0 0", nm, u_if.out_valid, u_if.in_ready, u_if.ldM);
      end
      @(posedge clk); #2;
    end
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
    #1;
    checks++;
    if (u_if.busy !== 1'b0 || u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: busy=%b in_ready=%b out_valid=%b, required 0 1 0", nm, u_if.busy, u_if.in_ready, u_if.out_valid);
    end
    if (stall > 0) begin
      checks++;
      if (u_if.ldM !== 1'b1) begin
        errors++;
        $display("FAIL %s_next_m: ldM=%b, required 1", nm, u_if.ldM);
      end
      u_if.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    u_if.in_valid = 1'b1;
    #2;
    checks++;
    if (w_strb !== 10'b0 || u_if.in_ready !== 1'b1 || u_if.busy !== 1'b0 || u_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: strobes=%b in_ready=%b busy=%b out_valid=%b, required 0 1 0 0", w_strb, u_if.in_ready, u_if.busy, u_if.out_valid);
    end
    u_if.in_valid = 1'b0;
    @(negedge clk) clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_sub();
    int n = 0;
    send_word(16'd3, 1'b0);
    send_word(16'd5, 1'b1);
    while (!(u_if.ldA && u_if.oper) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (!(u_if.ldA && u_if.oper)) begin
      errors++;
      $display("FAIL rst_sub_reach: ldA=%b oper=%b, required 1 1", u_if.ldA, u_if.oper);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (w_strb !== 10'b0 || u_if.in_ready !== 1'b1 || u_if.busy !== 1'b0 || u_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: strobes=%b in_ready=%b busy=%b out_valid=%b, required 0 1 0 0", w_strb, u_if.in_ready, u_if.busy, u_if.out_valid);
    end
    @(negedge clk) clr = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_stay_idle: busy=%b, required 0", u_if.busy);
    end
  endtask

  task automatic test_abort();
    // ignored in IDLE: M is still taken
    u_if.abort = 1'b1;
    bus_data = 16'h0007;
    u_if.in_valid = 1'b1;
    #1;
    checks++;
    if (u_if.ldM !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: ldM=%b, required 1", u_if.ldM);
    end
    @(posedge clk); #2;
    checks++;
    if (w_strb !== 10'b0 || u_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_waitq: strobes=%b busy=%b, required 0 1", w_strb, u_if.busy);
    end
    @(posedge clk); #1;
    u_if.abort = 1'b0;
    u_if.in_valid = 1'b0;
    #1;
    checks++;
    if (u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_waitq_idle: busy=%b, required 0", u_if.busy);
    end
    // Q even, so the state after EVAL is SHIFT
    send_word(16'd7, 1'b0);
    send_word(16'd6, 1'b1);
    @(posedge clk); #1;
    u_if.abort = 1'b1;
    #1;
    checks++;
    if (w_strb !== 10'b0 || u_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_shift: strobes=%b busy=%b, required 0 1", w_strb, u_if.busy);
    end
    @(posedge clk); #1;
    u_if.abort = 1'b0;
    #1;
    checks++;
    if (u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_shift_idle: busy=%b, required 0", u_if.busy);
    end
    run_op(16'd7, 16'd6, 0, "m7q6");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.abort     = 1'b0;
    test_reset();
    run_op(16'd3, 16'd0, 0, "m3q0");
    run_op(16'd3, 16'd5, 0, "m3q5");
    run_op(16'hFFFE, 16'hFFFF, 0, "neg");
    run_op(16'h1234, 16'h8001, 10, "stall");
    test_reset_mid_sub();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
